// File: rtl/imm_encoder.sv
// Encodes opcode, register fields and a 32-bit signed immediate into an RV32I instruction word.
// Two-stage valid/ready pipeline; define IMM_ENC_TRUNC_EN to emit the truncated packing on range/alignment errors.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [2:0]       out_err,
    output logic [CNT_W-1:0] err_count
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // a producer holding valid keeps its payload stable until that edge, and ready never
    // depends on valid.

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_R,
        FMT_X
    } fmt_e;

    localparam logic [2:0]  ERR_OK    = 3'd0;
    localparam logic [2:0]  ERR_RANGE = 3'd1;
    localparam logic [2:0]  ERR_ODD   = 3'd2;
    localparam logic [2:0]  ERR_ULOW  = 3'd3;
    localparam logic [2:0]  ERR_OPC   = 3'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic fmt_e classify(input logic [6:0] op);
        fmt_e f;
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: f = FMT_I;
            7'b0100011:                         f = FMT_S;
            7'b1100011:                         f = FMT_B;
            7'b0110111, 7'b0010111:             f = FMT_U;
            7'b1101111:                         f = FMT_J;
            7'b0110011:                         f = FMT_R;
            default:                            f = FMT_X;
        endcase
        return f;
    endfunction

    // Stage S1 registers
    logic        s1_valid;
    fmt_e        s1_fmt;
    logic [2:0]  s1_err;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [6:0]  s1_funct7;
    logic [31:0] s1_imm;

    // Input-side classification and error code
    fmt_e       in_fmt;
    logic [2:0] in_err;
    logic       fits_12;
    logic       fits_b;
    logic       fits_j;

    assign fits_12 = ($signed(in_imm) >= -32'sd2048)    && ($signed(in_imm) <= 32'sd2047);
    assign fits_b  = ($signed(in_imm) >= -32'sd4096)    && ($signed(in_imm) <= 32'sd4094);
    assign fits_j  = ($signed(in_imm) >= -32'sd1048576) && ($signed(in_imm) <= 32'sd1048574);

    always_comb begin
        in_fmt = classify(in_opcode);
        in_err = ERR_OK;
        case (in_fmt)
            FMT_I, FMT_S: begin
                if (!fits_12) in_err = ERR_RANGE;
            end
            FMT_B: begin
                if (!fits_b)        in_err = ERR_RANGE;
                else if (in_imm[0]) in_err = ERR_ODD;
            end
            FMT_J: begin
                if (!fits_j)        in_err = ERR_RANGE;
                else if (in_imm[0]) in_err = ERR_ODD;
            end
            FMT_U: begin
                if (in_imm[11:0] != 12'd0) in_err = ERR_ULOW;
            end
            FMT_R:   in_err = ERR_OK;
            default: in_err = ERR_OPC;
        endcase
    end

    // Packing of the S1 contents into an instruction word
    logic [31:0] s1_packed;
    logic [31:0] s1_instr;

    always_comb begin
        s1_packed = NOP_INSTR;
        case (s1_fmt)
            FMT_I: s1_packed = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_S: s1_packed = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            FMT_B: s1_packed = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                                s1_imm[4:1], s1_imm[11], s1_opcode};
            FMT_U: s1_packed = {s1_imm[31:12], s1_rd, s1_opcode};
            FMT_J: s1_packed = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                s1_rd, s1_opcode};
            FMT_R: s1_packed = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
            default: s1_packed = NOP_INSTR;
        endcase
    end

    always_comb begin
        s1_instr = s1_packed;
        if (s1_err == ERR_OPC) begin
            s1_instr = NOP_INSTR;
        end else if (s1_err != ERR_OK) begin
`ifdef IMM_ENC_TRUNC_EN
            s1_instr = s1_packed;
`else
            s1_instr = NOP_INSTR;
`endif
        end
    end

    // Stage advance: a stage loads when it is empty or its contents leave this cycle
    logic s2_load;
    logic out_fire;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= FMT_X;
            s1_err    <= ERR_OK;
            s1_opcode <= 7'd0;
            s1_rd     <= 5'd0;
            s1_rs1    <= 5'd0;
            s1_rs2    <= 5'd0;
            s1_funct3 <= 3'd0;
            s1_funct7 <= 7'd0;
            s1_imm    <= 32'd0;
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_err   <= ERR_OK;
            err_count <= '0;
        end else begin
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_instr <= s1_instr;
                    out_err   <= s1_err;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_fmt    <= in_fmt;
                    s1_err    <= in_err;
                    s1_opcode <= in_opcode;
                    s1_rd     <= in_rd;
                    s1_rs1    <= in_rs1;
                    s1_rs2    <= in_rs2;
                    s1_funct3 <= in_funct3;
                    s1_funct7 <= in_funct7;
                    s1_imm    <= in_imm;
                end
            end
            // Saturating count of errored outputs actually handed downstream
            if (out_fire && (out_err != ERR_OK) && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder: formats, error codes, boundaries,
// backpressure ordering, mid-stream reset and error-counter saturation.
module tb_imm_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [2:0]  out_err;
    logic [15:0] err_count;

    int vectors;
    int miscompares;
    logic [31:0] exp_q[$];

    imm_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Driver: one transaction through an otherwise idle pipeline with out_ready held high
    task automatic xact(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm,
                        output logic [31:0] instr, output logic [2:0] err, output int lat);
        int n;
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        in_valid = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid) begin
            instr = out_instr;
            err   = out_err;
        end else begin
            instr = 'x;
            err   = 'x;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out_instr got %h want 00000000", out_instr); end
        vectors++; if (out_err !== 3'd0) begin miscompares++; $display("FAIL reset_out_err got %0d want 0", out_err); end
        vectors++; if (err_count !== 16'h0) begin miscompares++; $display("FAIL reset_err_count got %h want 0000", err_count); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_i_type();
        logic [31:0] instr; logic [2:0] err; int lat;
        xact(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, instr, err, lat);
        vectors++; if (instr !== 32'hFFF10093) begin miscompares++; $display("FAIL i_neg1_instr got %h want fff10093", instr); end
        vectors++; if (err !== 3'd0) begin miscompares++; $display("FAIL i_neg1_err got %0d want 0", err); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL i_latency got %0d want 2", lat); end
        xact(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2047, instr, err, lat);
        vectors++; if (instr !== 32'h7FF10093) begin miscompares++; $display("FAIL i_2047_instr got %h want 7ff10093", instr); end
        vectors++; if (err !== 3'd0) begin miscompares++; $display("FAIL i_2047_err got %0d want 0", err); end
        xact(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, -32'sd2048, instr, err, lat);
        vectors++; if (instr !== 32'h80010093) begin miscompares++; $display("FAIL i_m2048_instr got %h want 80010093", instr); end
        vectors++; if (err !== 3'd0) begin miscompares++; $display("FAIL i_m2048_err got %0d want 0", err); end
        xact(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, instr, err, lat);
`ifdef IMM_ENC_TRUNC_EN
        vectors++; if (instr !== 32'h80010093) begin miscompares++; $display("FAIL i_2048_instr got %h want 80010093", instr); end
`else
        vectors++; if (instr !== 32'h00000013) begin miscompares++; $display("FAIL i_2048_instr got %h want 00000013", instr); end
`endif
        vectors++; if (err !== 3'd1) begin miscompares++; $display("FAIL i_2048_err got %0d want 1", err); end
    endtask

    task automatic test_other_formats();
        logic [31:0] instr; logic [2:0] err; int lat;
        xact(7'b0110011, 5'd3, 5'd4, 5'd5, 3'd0, 7'b0100000, 32'hDEAD_BEEF, instr, err, lat);
        vectors++; if (instr !== 32'h405201B3) begin miscompares++; $display("FAIL r_sub_instr got %h want 405201b3", instr); end
        vectors++; if (err !== 3'd0) begin miscompares++; $display("FAIL r_sub_err got %0d want 0", err); end
        xact(7'b0100011, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'd8, instr, err, lat);
        vectors++; if (instr !== 32'h00312423) begin miscompares++; $display("FAIL s_sw_instr got %h want 00312423", instr); end
        xact(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, instr, err, lat);
        vectors++; if (instr !== 32'h001000EF) begin miscompares++; $display("FAIL j_2048_instr got %h want 001000ef", instr); end
        vectors++; if (err !== 3'd0) begin miscompares++; $display("FAIL j_2048_err got %0d want 0", err); end
        xact(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, instr, err, lat);
        vectors++; if (err !== 3'd2) begin miscompares++; $display("FAIL j_odd_err got %0d want 2", err); end
        xact(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576, instr, err, lat);
        vectors++; if (err !== 3'd1) begin miscompares++; $display("FAIL j_range_err got %0d want 1", err); end
        xact(7'b1111111, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd3, instr, err, lat);
        vectors++; if (instr !== 32'h00000013) begin miscompares++; $display("FAIL illegal_instr got %h want 00000013", instr); end
        vectors++; if (err !== 3'd4) begin miscompares++; $display("FAIL illegal_err got %0d want 4", err); end
    endtask

    task automatic test_u_type();
        logic [31:0] instr; logic [2:0] err; int lat;
        xact(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, instr, err, lat);
        vectors++; if (instr !== 32'h123452B7) begin miscompares++; $display("FAIL u_ok_instr got %h want 123452b7", instr); end
        vectors++; if (err !== 3'd0) begin miscompares++; $display("FAIL u_ok_err got %0d want 0", err); end
        xact(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, instr, err, lat);
`ifdef IMM_ENC_TRUNC_EN
        vectors++; if (instr !== 32'h123452B7) begin miscompares++; $display("FAIL u_low_instr got %h want 123452b7", instr); end
`else
        vectors++; if (instr !== 32'h00000013) begin miscompares++; $display("FAIL u_low_instr got %h want 00000013", instr); end
`endif
        vectors++; if (err !== 3'd3) begin miscompares++; $display("FAIL u_low_err got %0d want 3", err); end
    endtask

    task automatic test_b_type();
        logic [31:0] instr; logic [2:0] err; int lat;
        do_reset();
        xact(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, instr, err, lat);
        vectors++; if (instr !== 32'hFE208EE3) begin miscompares++; $display("FAIL b_m4_instr got %h want fe208ee3", instr); end
        vectors++; if (err !== 3'd0) begin miscompares++; $display("FAIL b_m4_err got %0d want 0", err); end
        xact(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd3, instr, err, lat);
        vectors++; if (err !== 3'd2) begin miscompares++; $display("FAIL b_m3_err got %0d want 2", err); end
        xact(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096, instr, err, lat);
        vectors++; if (err !== 3'd1) begin miscompares++; $display("FAIL b_4096_err got %0d want 1", err); end
`ifdef IMM_ENC_TRUNC_EN
        vectors++; if (instr !== 32'h80208063) begin miscompares++; $display("FAIL b_4096_instr got %h want 80208063", instr); end
`else
        vectors++; if (instr !== 32'h00000013) begin miscompares++; $display("FAIL b_4096_instr got %h want 00000013", instr); end
`endif
        vectors++; if (err_count !== 16'd2) begin miscompares++; $display("FAIL b_err_count got %0d want 2", err_count); end
        xact(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4094, instr, err, lat);
        vectors++; if (instr !== 32'h7E208FE3) begin miscompares++; $display("FAIL b_4094_instr got %h want 7e208fe3", instr); end
        vectors++; if (err !== 3'd0) begin miscompares++; $display("FAIL b_4094_err got %0d want 0", err); end
    endtask

    task automatic test_back_to_back();
        int sent, got, last;
        logic [31:0] e;
        exp_q.delete();
        out_ready = 1'b0;
        sent = 0; got = 0; last = -1;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (cyc == 3) begin
                vectors++; if (out_instr !== 32'h00100093) begin miscompares++; $display("FAIL bp_hold_c3 got %h want 00100093", out_instr); end
            end
            if (cyc == 6) begin
                vectors++; if (sent !== 2) begin miscompares++; $display("FAIL bp_accepted got %0d want 2", sent); end
                vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
                vectors++; if (out_instr !== 32'h00100093) begin miscompares++; $display("FAIL bp_hold_c6 got %h want 00100093", out_instr); end
                out_ready = 1'b1;
                #1;
            end
            in_valid  = (sent < 4);
            in_opcode = 7'b0010011;
            in_rd     = 5'(sent + 1);
            in_rs1    = 5'd0;
            in_funct3 = 3'd0;
            in_imm    = 32'(sent + 1);
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                vectors++; if (out_instr !== e) begin miscompares++; $display("FAIL bp_order got %h want %h", out_instr, e); end
                if (got > 0) begin
                    vectors++; if (last !== cyc - 1) begin miscompares++; $display("FAIL bp_gap last %0d now %0d", last, cyc); end
                end
                last = cyc;
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back((32'(sent + 1) << 20) | (32'(sent + 1) << 7) | 32'h13);
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        vectors++; if (got !== 4) begin miscompares++; $display("FAIL bp_delivered got %0d want 4", got); end
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b0;
        in_opcode = 7'b1111111;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rm_inflight got %b want 1", out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_out_valid got %b want 0", out_valid); end
        vectors++; if (err_count !== 16'd0) begin miscompares++; $display("FAIL rm_err_count got %0d want 0", err_count); end
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rm_stale got %0d outputs want 0", seen); end
    endtask

    task automatic test_saturation();
        int del, cyc;
        bit chk100;
        do_reset();
        in_opcode = 7'b1111111;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        del = 0; cyc = 0; chk100 = 0;
        while (del < 65535 && cyc < 70000) begin
            if (out_valid && out_ready) del++;
            @(posedge clk); #1;
            cyc++;
            if (del == 100 && !chk100) begin
                chk100 = 1;
                vectors++; if (err_count !== 16'd100) begin miscompares++; $display("FAIL sat_mid got %0d want 100", err_count); end
            end
        end
        in_valid = 1'b0;
        vectors++; if (err_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach got %h want ffff", err_count); end
        repeat (4) begin
            @(posedge clk); #1;
        end
        vectors++; if (err_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold got %h want ffff", err_count); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sat_drain got %b want 0", out_valid); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
        out_ready = 1'b1;
        test_reset();
        test_i_type();
        test_other_formats();
        test_u_type();
        test_b_type();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
